// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Walks the columns of a 4x4 keypad one-hot, samples the rows through a
//   2-FF synchronizer and debounces both press and release of a single key.
//   On an accepted press the column/row pair is latched one cycle before
//   key_pressed rises, so a rising-edge consumer always sees settled data.
//
// Ports
//   clk           : single clock, rising edge
//   rst           : asynchronous, active-high reset
//   row_in[3:0]   : raw rows, active-high, asynchronous to clk
//   col_out[3:0]  : one-hot column drive
//   col_shift_reg : one-hot column of the last accepted key
//   row_capture   : one-hot row of the last accepted key
//   key_pressed   : high while the accepted key is held (debounced)
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] col_shift_reg,
  output logic [3:0] row_capture,
  output logic       key_pressed
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    SCAN     = 3'd0,
    DEBOUNCE = 3'd1,
    ARM      = 3'd2,
    PRESSED  = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [3:0]       s1, row_sync;
  logic [DIV_W-1:0] div_cnt, div_n;
  logic [DB_W-1:0]  db_cnt, db_n;
  logic [3:0]       cand, cand_n;
  logic [3:0]       col_n, csr_n, rcap_n;
  logic             kp_n;
  logic             row_onehot;
  logic [3:0]       col_next;

  // Ghosting / multi-key patterns are not one-hot and are never debounced.
  assign row_onehot = (row_sync != 4'b0000) && ((row_sync & (row_sync - 4'd1)) == 4'b0000);
  assign col_next   = {col_out[2:0], col_out[3]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1            <= 4'b0000;
      row_sync      <= 4'b0000;
      state         <= SCAN;
      div_cnt       <= '0;
      db_cnt        <= '0;
      cand          <= 4'b0000;
      col_out       <= 4'b0001;
      col_shift_reg <= 4'b0000;
      row_capture   <= 4'b0000;
      key_pressed   <= 1'b0;
    end else begin
      s1            <= row_in;
      row_sync      <= s1;
      state         <= state_n;
      div_cnt       <= div_n;
      db_cnt        <= db_n;
      cand          <= cand_n;
      col_out       <= col_n;
      col_shift_reg <= csr_n;
      row_capture   <= rcap_n;
      key_pressed   <= kp_n;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    db_n    = db_cnt;
    cand_n  = cand;
    col_n   = col_out;
    csr_n   = col_shift_reg;
    rcap_n  = row_capture;
    kp_n    = key_pressed;
    unique case (state)
      SCAN: begin
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          // Decide only at the end of the dwell so the synchronizer has
          // caught up with the rows of the column currently driven.
          if (row_onehot) begin
            cand_n  = row_sync;
            db_n    = '0;
            state_n = DEBOUNCE;
          end else begin
            col_n = col_next;
          end
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      DEBOUNCE: begin
        if (row_sync != cand) begin
          state_n = SCAN;
          col_n   = col_next;
          div_n   = '0;
        end else if (db_cnt == DB_LAST) begin
          csr_n   = col_out;
          rcap_n  = cand;
          state_n = ARM;
        end else begin
          db_n = db_cnt + DB_W'(1);
        end
      end
      ARM: begin
        // Data was latched last cycle; strobe now so it is already stable.
        kp_n    = 1'b1;
        state_n = PRESSED;
      end
      PRESSED: begin
        if (row_sync != cand) begin
          db_n    = '0;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (row_sync == cand) begin
          state_n = PRESSED;
        end else if (db_cnt == DB_LAST) begin
          kp_n    = 1'b0;
          state_n = SCAN;
          col_n   = col_next;
          div_n   = '0;
        end else begin
          db_n = db_cnt + DB_W'(1);
        end
      end
      default: state_n = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
//   A behavioural keypad drives row_in from col_out and the currently held
//   key. A table of {key, cycles to advance, expected outputs} walks idle
//   scanning, a clean press/release, press and release bounce and a
//   multi-hit; asynchronous reset cases are hand-written afterwards.
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] row_in;
  logic [3:0] col_out, col_shift_reg, row_capture;
  logic       key_pressed;

  // held key: rows in key_row appear whenever a column in key_col is driven
  logic [3:0] key_col, key_row;

  int checks = 0;
  int errors = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .row_in        (row_in),
    .col_out       (col_out),
    .col_shift_reg (col_shift_reg),
    .row_capture   (row_capture),
    .key_pressed   (key_pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'b0000;
    if ((col_out & key_col) != 4'b0000) row_in = key_row;
  end

  typedef struct {
    logic [3:0] kcol;
    logic [3:0] krow;
    int         cyc;
    logic [3:0] col;
    logic [3:0] csr;
    logic [3:0] rcap;
    logic       kp;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] col, input logic [3:0] csr,
                         input logic [3:0] rcap, input logic kp);
    chk({nm, ".col_out"}, col_out, col);
    chk({nm, ".col_shift_reg"}, col_shift_reg, csr);
    chk({nm, ".row_capture"}, row_capture, rcap);
    chk({nm, ".key_pressed"}, {3'b000, key_pressed}, {3'b000, kp});
  endtask

  function automatic vec_t mk(input logic [3:0] kcol, input logic [3:0] krow, input int cyc,
                              input logic [3:0] col, input logic [3:0] csr,
                              input logic [3:0] rcap, input logic kp);
    vec_t v;
    v.kcol = kcol; v.krow = krow; v.cyc = cyc;
    v.col = col; v.csr = csr; v.rcap = rcap; v.kp = kp;
    return v;
  endfunction

  initial begin
    int cnt;
    // times in comments are edges counted from reset release
    // reset / idle scan
    vecs[0]  = mk(4'b0000, 4'b0000, 0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    vecs[1]  = mk(4'b0000, 4'b0000, 3, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    vecs[2]  = mk(4'b0000, 4'b0000, 1, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    vecs[3]  = mk(4'b0000, 4'b0000, 4, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    vecs[4]  = mk(4'b0000, 4'b0000, 4, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    vecs[5]  = mk(4'b0000, 4'b0000, 4, 4'b0001, 4'b0000, 4'b0000, 1'b0); // t=16
    // key '6': col 0010 from edge 20, accepted at E0=24
    vecs[6]  = mk(4'b0010, 4'b0100, 9, 4'b0010, 4'b0000, 4'b0000, 1'b0); // t=25 frozen
    vecs[7]  = mk(4'b0010, 4'b0100, 6, 4'b0010, 4'b0000, 4'b0000, 1'b0); // t=31
    vecs[8]  = mk(4'b0010, 4'b0100, 1, 4'b0010, 4'b0010, 4'b0100, 1'b0); // t=32 E0+8
    vecs[9]  = mk(4'b0010, 4'b0100, 1, 4'b0010, 4'b0010, 4'b0100, 1'b1); // t=33 E0+9
    vecs[10] = mk(4'b0010, 4'b0100, 5, 4'b0010, 4'b0010, 4'b0100, 1'b1); // t=38
    // release: first 0000 row_sync sample at edge 41, fall at 49
    vecs[11] = mk(4'b0000, 4'b0000, 10, 4'b0010, 4'b0010, 4'b0100, 1'b1); // t=48
    vecs[12] = mk(4'b0000, 4'b0000, 1, 4'b0100, 4'b0010, 4'b0100, 1'b0);  // t=49
    vecs[13] = mk(4'b0000, 4'b0000, 3, 4'b0100, 4'b0010, 4'b0100, 1'b0);  // t=52
    vecs[14] = mk(4'b0000, 4'b0000, 1, 4'b1000, 4'b0010, 4'b0100, 1'b0);  // t=53
    // key '1' press bounce: E0=61, one-cycle drop seen at db count 5
    vecs[15] = mk(4'b0001, 4'b0001, 11, 4'b0001, 4'b0010, 4'b0100, 1'b0); // t=64
    vecs[16] = mk(4'b0000, 4'b0000, 1, 4'b0001, 4'b0010, 4'b0100, 1'b0);  // t=65
    vecs[17] = mk(4'b0001, 4'b0001, 2, 4'b0010, 4'b0010, 4'b0100, 1'b0);  // t=67 back to SCAN
    vecs[18] = mk(4'b0001, 4'b0001, 3, 4'b0010, 4'b0010, 4'b0100, 1'b0);  // t=70 no capture
    // stable hold accepted: E0=83, capture 91, strobe 92
    vecs[19] = mk(4'b0001, 4'b0001, 21, 4'b0001, 4'b0001, 4'b0001, 1'b0); // t=91
    vecs[20] = mk(4'b0001, 4'b0001, 1, 4'b0001, 4'b0001, 4'b0001, 1'b1);  // t=92
    // release bounce: 3-cycle drop
    vecs[21] = mk(4'b0000, 4'b0000, 3, 4'b0001, 4'b0001, 4'b0001, 1'b1);  // t=95
    vecs[22] = mk(4'b0001, 4'b0001, 10, 4'b0001, 4'b0001, 4'b0001, 1'b1); // t=105
    // real release: R0=108, fall 116
    vecs[23] = mk(4'b0000, 4'b0000, 10, 4'b0001, 4'b0001, 4'b0001, 1'b1); // t=115
    vecs[24] = mk(4'b0000, 4'b0000, 1, 4'b0010, 4'b0001, 4'b0001, 1'b0);  // t=116
    // multi-hit 0011 on column 0100 (driven from edge 120)
    vecs[25] = mk(4'b0100, 4'b0011, 8, 4'b1000, 4'b0001, 4'b0001, 1'b0);  // t=124
    vecs[26] = mk(4'b0100, 4'b0011, 4, 4'b0001, 4'b0001, 4'b0001, 1'b0);  // t=128

    key_col = 4'b0000;
    key_row = 4'b0000;
    rst     = 1'b1;
    tick(2);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      key_col = vecs[i].kcol;
      key_row = vecs[i].krow;
      tick(vecs[i].cyc);
      chk_all($sformatf("vec%0d", i), vecs[i].col, vecs[i].csr, vecs[i].rcap, vecs[i].kp);
    end

    // reset mid-DEBOUNCE: key '6' accepted at edge 136, in DEBOUNCE at 139
    key_col = 4'b0010;
    key_row = 4'b0100;
    tick(11);
    chk("mid_db.col_out", col_out, 4'b0010);
    rst = 1'b1;
    #2;
    chk_all("rst_db", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    #1;
    rst = 1'b0;

    // from reset: E0=8, strobe expected at edge 17
    cnt = 0;
    while (key_pressed !== 1'b1 && cnt < 40) begin
      tick(1);
      cnt++;
    end
    chk("press_latency", 4'(cnt), 4'(17));
    chk("pressed.col_shift_reg", col_shift_reg, 4'b0010);
    chk("pressed.row_capture", row_capture, 4'b0100);

    // reset mid-PRESSED, no clock edge between assert and check
    tick(2);
    rst = 1'b1;
    #2;
    chk_all("rst_pr", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    #1;
    rst     = 1'b0;
    key_col = 4'b0000;
    tick(3);
    chk_all("post_rst", 4'b0001, 4'b0000, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
